ga_sync_int: RTL and testbench

- Gate Array sync and interrupt stage, directly downstream of the CRTC.
- Consumes the CRTC's raw HSYNC/VSYNC at character rate (CLKEN, 1 MHz).
- Produces the monitor HSYNC/VSYNC, the 300 Hz Z80 interrupt (52-line counter, R52), and the line-synchronised screen mode latch used by the pixel shifter.

---
 rtl/ga_pkg.sv | 27 ++
 rtl/ga_hsync_shaper.sv | 70 +++++++
 rtl/ga_sync_int.sv | 164 ++++++++++++++++
 tb/tb_ga_sync_int.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ga_pkg.sv
// Shared constants, types and helpers for the Gate Array sync/interrupt stage.
package ga_pkg;

   localparam int unsigned INT_PERIOD = 52;
   localparam int unsigned HS_DELAY   = 2;
   localparam int unsigned HS_MAX     = 4;
   localparam int unsigned VS_DELAY   = 2;
   localparam int unsigned VS_LEN     = 4;

   localparam int unsigned R52_W  = 6;
   localparam int unsigned CNT_W  = 3;
   localparam int unsigned MODE_W = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      ACTIVE = 2'd2
   } hs_state_t;

   typedef logic [MODE_W-1:0] mode_t;

   // Delay counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/ga_hsync_shaper.sv
// Monitor HSYNC shaper: delays the CRTC HSYNC and clamps its width, at character rate.
module ga_hsync_shaper
   import ga_pkg::*;
#(
   parameter int unsigned P_HS_DELAY = HS_DELAY,
   parameter int unsigned P_HS_MAX   = HS_MAX
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clken,
   input  logic i_hsync,
   input  logic i_hsync_prev,
   output logic o_hsync,
   output logic o_start_c
);

   hs_state_t        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_inc;

   assign w_cnt_inc = sat_inc(r_cnt);

   // Same-clock strobe for the transition that raises o_hsync.
   assign o_start_c = i_clken && (r_state == DELAY) && i_hsync &&
                      (w_cnt_inc == CNT_W'(P_HS_DELAY));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         o_hsync <= 1'b0;
      end else if (i_clken) begin
         case (r_state)
            IDLE: begin
               if (i_hsync && !i_hsync_prev) begin
                  r_state <= DELAY;
                  r_cnt   <= '0;
               end
            end
            DELAY: begin
               if (!i_hsync) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else if (w_cnt_inc == CNT_W'(P_HS_DELAY)) begin
                  r_state <= ACTIVE;
                  r_cnt   <= '0;
                  o_hsync <= 1'b1;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            ACTIVE: begin
               if (!i_hsync || (w_cnt_inc == CNT_W'(P_HS_MAX))) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
                  o_hsync <= 1'b0;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
               o_hsync <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/ga_sync_int.sv
// Gate Array sync and interrupt stage: monitor syncs, R52 interrupt counter, line-synced mode latch.
// Optional GA_CSYNC_EN adds a registered composite sync output o_csync.
module ga_sync_int
   import ga_pkg::*;
#(
   parameter int unsigned P_INT_PERIOD = INT_PERIOD,
   parameter int unsigned P_HS_DELAY   = HS_DELAY,
   parameter int unsigned P_HS_MAX     = HS_MAX,
   parameter int unsigned P_VS_DELAY   = VS_DELAY,
   parameter int unsigned P_VS_LEN     = VS_LEN
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clken,
   input  logic             i_crtc_hsync,
   input  logic             i_crtc_vsync,
   input  logic             i_irq_ack,
   input  logic             i_int_reset,
   input  logic             i_mode_wr,
   input  mode_t            i_mode_in,
   output logic             o_int_n,
   output logic             o_hsync_out,
   output logic             o_vsync_out,
   output mode_t            o_mode,
   output logic [R52_W-1:0] o_r52
`ifdef GA_CSYNC_EN
   ,
   output logic             o_csync
`endif
);

   logic             r_hs_prev;
   logic             r_vs_prev;
   logic             r_vs_armed;
   logic [1:0]       r_vs_cnt;
   logic [CNT_W-1:0] r_vs_len_cnt;
   mode_t            r_pending;

   logic             w_hs_fall;
   logic             w_vs_rise;
   logic             w_hs_start;
   logic             w_resync;
   logic             w_wrap;
   logic             w_raise;
   logic [1:0]       w_vs_cnt_inc;
   logic [R52_W-1:0] w_r52_inc;
   logic [R52_W-1:0] w_r52_evt;
   logic [CNT_W-1:0] w_vs_len_inc;

   ga_hsync_shaper #(
      .P_HS_DELAY (P_HS_DELAY),
      .P_HS_MAX   (P_HS_MAX)
   ) u_hsync_shaper (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_clken      (i_clken),
      .i_hsync      (i_crtc_hsync),
      .i_hsync_prev (r_hs_prev),
      .o_hsync      (o_hsync_out),
      .o_start_c    (w_hs_start)
   );

   // Counter events: the VSYNC resync replaces the plain increment on its edge.
   always_comb begin
      w_hs_fall    = i_clken & r_hs_prev & ~i_crtc_hsync;
      w_vs_rise    = i_clken & ~r_vs_prev & i_crtc_vsync;
      w_vs_cnt_inc = r_vs_cnt + 2'd1;
      w_vs_len_inc = sat_inc(r_vs_len_cnt);
      w_r52_inc    = o_r52 + R52_W'(1);
      w_resync     = w_hs_fall & r_vs_armed & (w_vs_cnt_inc == 2'(P_VS_DELAY));
      w_wrap       = w_hs_fall & ~w_resync & (w_r52_inc == R52_W'(P_INT_PERIOD));
      w_raise      = w_wrap | (w_resync & o_r52[R52_W-1]);
      w_r52_evt    = o_r52;
      if (w_resync || w_wrap) begin
         w_r52_evt = '0;
      end else if (w_hs_fall) begin
         w_r52_evt = w_r52_inc;
      end
   end

   // Interrupt line and R52; INT_RESET first, then a raising event, then IRQ_ACK.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_r52   <= '0;
         o_int_n <= 1'b1;
      end else if (i_int_reset) begin
         o_r52   <= '0;
         o_int_n <= 1'b1;
      end else if (w_raise) begin
         o_r52   <= '0;
         o_int_n <= 1'b0;
      end else if (i_irq_ack) begin
         o_r52   <= {1'b0, w_r52_evt[R52_W-2:0]};
         o_int_n <= 1'b1;
      end else begin
         o_r52 <= w_r52_evt;
      end
   end

   // Sync edge history, VSYNC arming and monitor VSYNC pulse.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hs_prev    <= 1'b0;
         r_vs_prev    <= 1'b0;
         r_vs_armed   <= 1'b0;
         r_vs_cnt     <= '0;
         r_vs_len_cnt <= '0;
         o_vsync_out  <= 1'b0;
      end else begin
         if (i_clken) begin
            r_hs_prev <= i_crtc_hsync;
            r_vs_prev <= i_crtc_vsync;
         end
         if (r_vs_armed) begin
            if (w_resync) begin
               r_vs_armed <= 1'b0;
               r_vs_cnt   <= '0;
            end else if (w_hs_fall) begin
               r_vs_cnt <= w_vs_cnt_inc;
            end
         end else if (w_vs_rise) begin
            r_vs_armed <= 1'b1;
            r_vs_cnt   <= '0;
         end
         if (w_resync) begin
            o_vsync_out  <= 1'b1;
            r_vs_len_cnt <= '0;
         end else if (o_vsync_out && w_hs_fall) begin
            if (w_vs_len_inc == CNT_W'(P_VS_LEN)) begin
               o_vsync_out  <= 1'b0;
               r_vs_len_cnt <= '0;
            end else begin
               r_vs_len_cnt <= w_vs_len_inc;
            end
         end
      end
   end

   // A write landing on the HSYNC_OUT rise is picked up on the following line.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pending <= '0;
         o_mode    <= '0;
      end else begin
         if (w_hs_start) begin
            o_mode <= r_pending;
         end
         if (i_mode_wr) begin
            r_pending <= i_mode_in;
         end
      end
   end

`ifdef GA_CSYNC_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_csync <= 1'b0;
      end else begin
         o_csync <= o_hsync_out ^ o_vsync_out;
      end
   end
`endif

endmodule

// File: tb/tb_ga_sync_int.sv
// Scoreboard bench for ga_sync_int: character-rate CRTC lines, interrupt, sync and mode checks.
module tb_ga_sync_int;
   import ga_pkg::*;

   localparam int LINE = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clken = 1'b0;
   logic       crtc_hs = 1'b0;
   logic       crtc_vs = 1'b0;
   logic       irq_ack = 1'b0;
   logic       int_reset = 1'b0;
   logic       mode_wr = 1'b0;
   logic [1:0] mode_in = 2'd0;
   logic       int_n;
   logic       hs_out;
   logic       vs_out;
   logic [1:0] mode;
   logic [5:0] r52;
`ifdef GA_CSYNC_EN
   logic       csync;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   int         exp_q[$];
   int         ln_hs_hi;
   int         ln_hs_rise;
   logic [1:0] ln_mode_rise;
   int         ln_vs_hi;

   ga_sync_int u_dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_clken      (clken),
      .i_crtc_hsync (crtc_hs),
      .i_crtc_vsync (crtc_vs),
      .i_irq_ack    (irq_ack),
      .i_int_reset  (int_reset),
      .i_mode_wr    (mode_wr),
      .i_mode_in    (mode_in),
      .o_int_n      (int_n),
      .o_hsync_out  (hs_out),
      .o_vsync_out  (vs_out),
      .o_mode       (mode),
      .o_r52        (r52)
`ifdef GA_CSYNC_EN
      ,
      .o_csync      (csync)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // One character: strobes are high for exactly the CLKEN clock.
   task automatic char_step(input bit hs, input bit vs, input bit wr, input logic [1:0] wv,
                            input bit ir, input bit ack);
      @(negedge clk);
      crtc_hs = hs; crtc_vs = vs; mode_wr = wr; mode_in = wv;
      int_reset = ir; irq_ack = ack; clken = 1'b1;
      @(negedge clk);
      clken = 1'b0; mode_wr = 1'b0; int_reset = 1'b0; irq_ack = 1'b0;
   endtask

   task automatic run_line(input int width, input bit vs, input int wr_char, input logic [1:0] wv,
                           input int ir_char, input int ack_char);
      ln_hs_hi = 0; ln_hs_rise = -1; ln_mode_rise = 2'd0; ln_vs_hi = 0;
      for (int c = 0; c < LINE; c++) begin
         char_step(c < width, vs, c == wr_char, wv, c == ir_char, c == ack_char);
         if (hs_out === 1'b1) begin
            if (ln_hs_rise < 0) begin
               ln_hs_rise   = c;
               ln_mode_rise = mode;
            end
            ln_hs_hi++;
         end
         if (vs_out === 1'b1) ln_vs_hi++;
      end
   endtask

   task automatic run_lines(input int n);
      repeat (n) run_line(14, 1'b0, -1, 2'd0, -1, -1);
   endtask

   task automatic pulse_ack();
      @(negedge clk); irq_ack = 1'b1;
      @(negedge clk); irq_ack = 1'b0;
   endtask

   task automatic pulse_int_reset();
      @(negedge clk); int_reset = 1'b1;
      @(negedge clk); int_reset = 1'b0;
   endtask

   task automatic check_counter(input string tag, input int exp_r52, input bit exp_int);
      int e;
      exp_q.push_back(exp_r52);
      exp_q.push_back(int'(exp_int));
      e = exp_q.pop_front();
      n_cmp++;
      if (int'(r52) !== e) begin
         n_bad++; $display("FAIL %s r52: got %0d want %0d", tag, r52, e);
      end
      e = exp_q.pop_front();
      n_cmp++;
      if (int'(int_n) !== e) begin
         n_bad++; $display("FAIL %s int_n: got %b want %0d", tag, int_n, e);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_counter("reset", 0, 1'b1);
      n_cmp++; if (hs_out !== 1'b0) begin n_bad++; $display("FAIL reset_hsync: got %b want 0", hs_out); end
      n_cmp++; if (vs_out !== 1'b0) begin n_bad++; $display("FAIL reset_vsync: got %b want 0", vs_out); end
      n_cmp++; if (mode !== 2'd0) begin n_bad++; $display("FAIL reset_mode: got %0d want 0", mode); end
   endtask

   task automatic test_int_period();
      int e;
      for (int i = 1; i <= 60; i++) begin
         e = (i < 52) ? i : (i - 52);
         run_line(14, 1'b0, -1, 2'd0, -1, -1);
         check_counter($sformatf("int_line%0d", i), e, i < 52);
      end
   endtask

   task automatic test_irq_ack();
      run_lines(32);
      check_counter("ack_pre40", 40, 1'b0);
      pulse_ack();
      check_counter("ack_at40", 8, 1'b1);
      pulse_int_reset();
      run_lines(20);
      pulse_ack();
      check_counter("ack_at20", 20, 1'b1);
      run_lines(18);
      run_line(14, 1'b0, -1, 2'd0, -1, 14);
      check_counter("ack_with_inc", 7, 1'b1);
      pulse_int_reset();
      check_counter("int_reset", 0, 1'b1);
      run_lines(51);
      run_line(14, 1'b0, -1, 2'd0, -1, 14);
      check_counter("ack_vs_wrap", 0, 1'b0);
   endtask

   task automatic test_vsync_resync();
      int total;
      pulse_int_reset();
      run_lines(35);
      run_line(14, 1'b1, -1, 2'd0, -1, -1);
      check_counter("vs35_edge1", 36, 1'b1);
      total = ln_vs_hi;
      n_cmp++; if (ln_vs_hi !== 0) begin n_bad++; $display("FAIL vsout_line1: got %0d want 0", ln_vs_hi); end
      run_line(14, 1'b1, -1, 2'd0, -1, -1);
      check_counter("vs35_edge2", 0, 1'b0);
      total += ln_vs_hi;
      n_cmp++; if (ln_vs_hi !== 2) begin n_bad++; $display("FAIL vsout_line2: got %0d want 2", ln_vs_hi); end
      for (int i = 0; i < 4; i++) begin
         run_line(14, 1'b0, -1, 2'd0, -1, -1);
         total += ln_vs_hi;
      end
      n_cmp++; if (total !== 4 * LINE) begin n_bad++; $display("FAIL vsout_width: got %0d want %0d", total, 4 * LINE); end
      n_cmp++; if (vs_out !== 1'b0) begin n_bad++; $display("FAIL vsout_end: got %b want 0", vs_out); end
      pulse_int_reset();
      run_lines(10);
      run_line(14, 1'b1, -1, 2'd0, -1, -1);
      check_counter("vs10_edge1", 11, 1'b1);
      run_line(14, 1'b1, -1, 2'd0, -1, -1);
      check_counter("vs10_edge2", 0, 1'b1);
      run_lines(4);
   endtask

   task automatic test_hsync_widths();
      int widths[5] = '{14, 4, 2, 1, 0};
      int exp_w[5]  = '{4, 2, 0, 0, 0};
      int exp_r[5]  = '{2, 2, -1, -1, -1};
      int e;
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(exp_w[i]);
         exp_q.push_back(exp_r[i]);
         run_line(widths[i], 1'b0, -1, 2'd0, -1, -1);
         e = exp_q.pop_front();
         n_cmp++; if (ln_hs_hi !== e) begin n_bad++; $display("FAIL hs_width_w%0d: got %0d want %0d", widths[i], ln_hs_hi, e); end
         e = exp_q.pop_front();
         n_cmp++; if (ln_hs_rise !== e) begin n_bad++; $display("FAIL hs_rise_w%0d: got %0d want %0d", widths[i], ln_hs_rise, e); end
      end
   endtask

   task automatic test_mode();
      run_line(14, 1'b0, 8, 2'd2, -1, -1);
      n_cmp++; if (ln_mode_rise !== 2'd0) begin n_bad++; $display("FAIL mode_lineA_rise: got %0d want 0", ln_mode_rise); end
      n_cmp++; if (mode !== 2'd0) begin n_bad++; $display("FAIL mode_lineA_end: got %0d want 0", mode); end
      run_line(14, 1'b0, -1, 2'd0, -1, -1);
      n_cmp++; if (ln_mode_rise !== 2'd2) begin n_bad++; $display("FAIL mode_lineB_rise: got %0d want 2", ln_mode_rise); end
      run_line(14, 1'b0, 2, 2'd1, -1, -1);
      n_cmp++; if (ln_mode_rise !== 2'd2) begin n_bad++; $display("FAIL mode_lineC_rise: got %0d want 2", ln_mode_rise); end
      n_cmp++; if (mode !== 2'd2) begin n_bad++; $display("FAIL mode_lineC_end: got %0d want 2", mode); end
      run_line(14, 1'b0, -1, 2'd0, -1, -1);
      n_cmp++; if (ln_mode_rise !== 2'd1) begin n_bad++; $display("FAIL mode_lineD_rise: got %0d want 1", ln_mode_rise); end
   endtask

   task automatic test_async_reset();
      pulse_int_reset();
      run_lines(82);
      for (int c = 0; c < 4; c++) char_step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      check_counter("pre_reset", 30, 1'b0);
      n_cmp++; if (hs_out !== 1'b1) begin n_bad++; $display("FAIL pre_reset_hsync: got %b want 1", hs_out); end
      n_cmp++; if (mode !== 2'd1) begin n_bad++; $display("FAIL pre_reset_mode: got %0d want 1", mode); end
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check_counter("async_reset", 0, 1'b1);
      n_cmp++; if (hs_out !== 1'b0) begin n_bad++; $display("FAIL async_reset_hsync: got %b want 0", hs_out); end
      n_cmp++; if (vs_out !== 1'b0) begin n_bad++; $display("FAIL async_reset_vsync: got %b want 0", vs_out); end
      n_cmp++; if (mode !== 2'd0) begin n_bad++; $display("FAIL async_reset_mode: got %0d want 0", mode); end
      crtc_hs = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_int_reset_coincident();
      run_lines(51);
      check_counter("pre_52nd", 51, 1'b1);
      run_line(14, 1'b0, -1, 2'd0, 14, -1);
      check_counter("int_reset_52nd", 0, 1'b1);
   endtask

   initial begin
      test_reset();
      test_int_period();
      test_irq_ack();
      test_vsync_resync();
      test_hsync_widths();
      test_mode();
      test_async_reset();
      test_int_reset_coincident();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
